// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder
//   Pipelined WIDTH-bit add/subtract built from WIDTH/CHUNK ripple-carry
//   chunks, one chunk per stage, with the inter-chunk carry registered.
//   Latency is STAGES cycles, throughput one operation per cycle; the
//   whole pipe advances together and freezes completely under backpressure.
//
// Parameters
//   WIDTH  operand / result width
//   CHUNK  bits added per stage (WIDTH must be a multiple of CHUNK)
//   STAGES derived: WIDTH/CHUNK, equals the pipeline depth
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = !out_valid | out_ready)
//   a, b, cin, sub       operands; sub=0: a+b+cin, sub=1: a-b (cin ignored)
//   out_valid/out_ready  result handshake
//   sum, cout            result modulo 2^WIDTH; cout is no-borrow when sub=1
//   ovf                  signed overflow, present only with PCA_OVERFLOW_EN
//
// Optional feature macro: PCA_OVERFLOW_EN
module pipelined_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PCA_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CHUNK;
      localparam int BW = WIDTH - k * CHUNK;   // b' chunks still pending at this stage

      logic [WIDTH-1:0] w_in;
      logic [BW-1:0]    b_in;
      logic             c_in;
      logic             v_in;
      logic [CHUNK:0]   add;
      logic [WIDTH-1:0] w_nxt;

      // w carries finished sum chunks below LO+CHUNK and the still-unused
      // operand-A chunks above it, so skew and deskew share one register.
      logic             v;
      logic             c;
      logic [WIDTH-1:0] w;

      if (k == 0) begin : g_head
         assign w_in = a;
         assign b_in = sub ? ~b : b;
         assign c_in = sub | cin;
         assign v_in = in_valid;
      end else begin : g_body
         assign w_in = g_stage[k-1].w;
         assign b_in = g_stage[k-1].g_skew.bs;
         assign c_in = g_stage[k-1].c;
         assign v_in = g_stage[k-1].v;
      end

      always_comb begin
         add   = {1'b0, w_in[LO +: CHUNK]} + {1'b0, b_in[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, c_in};
         w_nxt = w_in;
         w_nxt[LO +: CHUNK] = add[CHUNK-1:0];
      end

      // Data only moves with a valid token; bubbles leave the registers as-is.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v <= 1'b0;
            c <= 1'b0;
            w <= '0;
         end else if (advance) begin
            v <= v_in;
            if (v_in) begin
               c <= add[CHUNK];
               w <= w_nxt;
            end
         end
      end

      if (k < LAST) begin : g_skew
         logic [BW-CHUNK-1:0] bs;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bs <= '0;
            end else if (advance && v_in) begin
               bs <= b_in[BW-1:CHUNK];
            end
         end
      end
   end

   assign out_valid = g_stage[LAST].v;
   assign sum       = g_stage[LAST].w;
   assign cout      = g_stage[LAST].c;

`ifdef PCA_OVERFLOW_EN
   // Carry into the MSB is recovered from the MSB sum bit: a ^ b' ^ s.
   logic ovf_nxt;

   assign ovf_nxt = (g_stage[LAST].w_in[WIDTH-1] ^ g_stage[LAST].b_in[CHUNK-1]
                     ^ g_stage[LAST].add[CHUNK-1]) ^ g_stage[LAST].add[CHUNK];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (advance && g_stage[LAST].v_in) begin
         ovf <= ovf_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb_pipelined_chunk_adder
//   Directed and randomized stimulus for pipelined_chunk_adder (WIDTH=32,
//   CHUNK=8) plus a single-stage instance (CHUNK=32). Expected results come
//   from plain integer arithmetic; expected timing comes from a queue of
//   in-flight operations, each due STAGES cycles after acceptance plus any
//   cycles the pipe spent stalled meanwhile.
module tb_pipelined_chunk_adder;

   localparam int W = 32;
   localparam int S = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b, sum;
   logic          cin, sub, cout;
   logic          in_valid1, in_ready1, out_valid1, out_ready1;
   logic [W-1:0]  sum1;
   logic          cout1;
`ifdef PCA_OVERFLOW_EN
   logic          ovf, ovf1;
`endif

   pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
`ifdef PCA_OVERFLOW_EN
      , .ovf(ovf)
`endif
   );

   pipelined_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1)
`ifdef PCA_OVERFLOW_EN
      , .ovf(ovf1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           c;
      int           st;
   } exp_t;

   exp_t q[$];
   int   n_cmp     = 0;
   int   n_bad     = 0;
   int   cycle     = 0;
   int   stall_cnt = 0;
   logic acc       = 1'b0;

   function automatic exp_t ref_op(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
      exp_t        e;
      logic [W:0]  full;
      longint      t;
      longint      sx = longint'($signed(x));
      longint      sy = longint'($signed(y));
      if (sb) begin
         e.s  = x - y;
         e.co = (x >= y);
         t    = sx - sy;
      end else begin
         full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
         e.s  = full[W-1:0];
         e.co = full[W];
         t    = sx + sy + longint'(ci);
      end
      e.ov = (t > longint'(32'sh7FFFFFFF)) || (t < longint'(32'sh80000000));
      e.c  = 0;
      e.st = 0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, then step past the rising edge.
   task automatic tick();
      exp_t h;
      logic ev;
      logic adv;
      @(negedge clk);
      acc = 1'b0;
      if (!rst_n) begin
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_sum",       64'(sum),       64'(0));
         chk("rst_cout",      64'(cout),      64'(0));
         chk("rst_in_ready",  64'(in_ready),  64'(1));
`ifdef PCA_OVERFLOW_EN
         chk("rst_ovf",       64'(ovf),       64'(0));
`endif
         q.delete();
      end else begin
         ev = 1'b0;
         if (q.size() > 0)
            ev = (cycle >= q[0].c + S + (stall_cnt - q[0].st));
         chk("out_valid", 64'(out_valid), 64'(ev));
         adv = !ev || out_ready;
         chk("in_ready", 64'(in_ready), 64'(adv));
         if (ev) begin
            h = q[0];
            chk("sum",  64'(sum),  64'(h.s));
            chk("cout", 64'(cout), 64'(h.co));
`ifdef PCA_OVERFLOW_EN
            chk("ovf",  64'(ovf),  64'(h.ov));
`endif
            if (out_ready) void'(q.pop_front());
         end
         if (in_valid && adv) begin
            h    = ref_op(a, b, cin, sub);
            h.c  = cycle;
            h.st = stall_cnt;
            q.push_back(h);
            acc = 1'b1;
         end
         if (!adv) stall_cnt++;
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
      a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (acc) break;
      end
      chk("send_accepted", 64'(acc), 64'(1));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(4))
         0:       return '0;
         1:       return '1;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic         vs [3];
      exp_t         e;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_valid1 = 1'b0; out_ready1 = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      idle(2);

      // carry ripples through every stage
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      idle(6);

      // subtract both ways; cin is ignored when subtracting
      send(32'd5, 32'd7, 1'b0, 1'b1);
      send(32'd7, 32'd5, 1'b0, 1'b1);
      send(32'd7, 32'd5, 1'b1, 1'b1);
      idle(6);

      // signed-overflow vectors
      send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      send(32'd3, 32'd4, 1'b0, 1'b0);
      idle(6);

      // streaming, one per cycle
      for (int i = 0; i < 6; i++)
         send(W'(i) * 32'h0101_0101, 32'h00FF_00FF, i[0], 1'b0);
      idle(8);

      // fill the pipe with the sink stalled, hold 3 cycles, then accept+retire together
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
      a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         tick();
         chk("stall_no_accept", 64'(acc), 64'(0));
      end
      out_ready = 1'b1;
      tick();
      chk("simul_accept", 64'(acc), 64'(1));
      idle(8);

      // randomized traffic; a refused operand is held by the source
      for (int i = 0; i < 200; i++) begin
         if (!(in_valid && !acc)) begin
            in_valid = ($urandom_range(3) != 0);
            a = pick(); b = pick();
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
         end
         out_ready = ($urandom_range(2) != 0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0) break;
         tick();
      end
      chk("drain_random", 64'(q.size()), 64'(0));

      // reset with operations in flight
      send(32'd100, 32'd1, 1'b0, 1'b0);
      send(32'd200, 32'd2, 1'b0, 1'b0);
      send(32'd300, 32'd3, 1'b1, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'(0));
      tick();
      rst_n = 1'b1;
      idle(8);
      send(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b1);
      idle(6);
      chk("drain_reset", 64'(q.size()), 64'(0));

      // single-stage instance: latency 1
      va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;       vs[0] = 1'b0;
      va[1] = 32'd5;         vb[1] = 32'd7;       vs[1] = 1'b1;
      va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vs[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = va[i]; b = vb[i]; cin = 1'b0; sub = vs[i]; in_valid1 = 1'b1;
         e = ref_op(va[i], vb[i], 1'b0, vs[i]);
         @(negedge clk);
         chk("s1_in_ready",  64'(in_ready1),  64'(1));
         chk("s1_idle",      64'(out_valid1), 64'(0));
         @(posedge clk);
         #1;
         in_valid1 = 1'b0;
         @(negedge clk);
         chk("s1_out_valid", 64'(out_valid1), 64'(1));
         chk("s1_sum",       64'(sum1),       64'(e.s));
         chk("s1_cout",      64'(cout1),      64'(e.co));
`ifdef PCA_OVERFLOW_EN
         chk("s1_ovf",       64'(ovf1),       64'(e.ov));
`endif
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("s1_retired", 64'(out_valid1), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into WIDTH/CHUNK ripple-carry chunks, one chunk per pipeline stage, with the carry registered between stages.
- Used as the modular-add primitive in the hashing datapath (32-bit word additions).
- Accepts one operation per cycle under a valid/ready handshake, with full backpressure.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- CHUNK, 8, bits added per stage. WIDTH % CHUNK must equal 0, otherwise elaboration fails.
- STAGES, WIDTH/CHUNK, derived and not overridable. Equals the pipeline depth and the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0 = A+B+cin, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry-out. When sub=1 this is the no-borrow flag: 1 when A >= B unsigned.

Behaviour:
- Reset: clk and reset are fixed as one clock, clk, with asynchronous active-low reset rst_n. Asserting rst_n low clears all stage valid bits, carries and data registers immediately. Outputs during and after reset: out_valid=0, sum=0, cout=0, in_ready=1.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. Operands are captured only on an input transfer.
- Pipeline advance: advance = !out_valid | out_ready, and in_ready = advance. The whole pipe shifts on advance and holds completely otherwise. There are no bubbles to collapse; a stalled pipe freezes all stages.
- Stage k (k = 0..STAGES-1) adds chunk k: a[k*CHUNK +: CHUNK] + b'[chunk k] + c_k, where:
  - b' = sub ? ~b : b.
  - c_0 = sub ? 1 : cin.
  - c_k for k > 0 is the registered carry-out of stage k-1.
- Skew and deskew: operand chunks above stage k travel through skew registers until they reach their stage. Completed lower sum chunks travel through deskew registers, so that all chunks of a result emerge in the same cycle.
- Latency: exactly STAGES cycles from the input transfer to out_valid, with no stalls. Throughput is 1 result per cycle.
- Outputs: cout is the carry-out of stage STAGES-1. sum and cout remain stable while out_valid=1 and out_ready=0.
- Stall boundary: if the pipe is full and out_ready=0, in_ready=0 and an in_valid presented that cycle is not accepted. Its data must be held by the source.
- Simultaneous events: out_ready=1 together with in_valid=1 on a full pipe accepts the input and retires the output in the same cycle.
- Reset mid-operation: all in-flight operations are discarded. No out_valid may appear for them after rst_n is released.
- Wrap-around: the sum is modulo 2^WIDTH, and the carry is reported only via cout.
- STAGES=1 degenerates to a single registered full-width ripple-carry adder with latency 1.

Optional Feature:
- Macro: PCA_OVERFLOW_EN.
- When defined, an extra output port ovf (output, 1 bit) is added. It flags two's-complement signed overflow: the carry into the MSB XOR the carry out of the MSB, computed in stage STAGES-1. ovf is aligned with sum, reset to 0, and held during a stall.
- When not defined, the port does not exist and no overflow logic is generated.

Test Plan:
- Reset and basic add (WIDTH=32, CHUNK=8): release rst_n, send a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after exactly 4 cycles, out_valid=1, sum=0x00000000, cout=1 (carry ripples through all 4 stages).
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0. Then a=7, b=5, sub=1 -> sum=0x00000002, cout=1. Set cin=1 with sub=1 -> result unchanged.
- Streaming: hold out_ready=1 and send 6 back-to-back operations, a=i*0x01010101, b=0x00FF00FF, cin=i&1 -> 6 consecutive results, one per cycle starting at cycle 4, matching the reference model.
- Backpressure: fill the pipe, then drop out_ready for 3 cycles -> in_ready=0, sum/cout/out_valid held constant, no result lost or duplicated after out_ready rises. Raise in_valid and out_ready together -> simultaneous accept and retire.
- Reset mid-flight: inject 3 operations, assert rst_n low for 1 cycle after the 2nd cycle -> out_valid=0 immediately and no stale outputs afterwards. A new operation after release completes in 4 cycles.
- With PCA_OVERFLOW_EN: a=0x7FFFFFFF, b=1, sub=0 -> ovf=1, sum=0x80000000. Then a=0x80000000, b=1, sub=1 -> ovf=1. Then a=3, b=4 -> ovf=0. Also run with CHUNK=32 (STAGES=1) -> latency 1.
